// File: rtl/pb_mode_ctrl.sv
// pb_mode_ctrl
// Push-button assist-level controller for the e-bike assist selector.
// One raw active-low button is synchronised, debounced and classified:
// a short press (released before the long threshold) advances the assist
// setting, and a long press forces the setting to 0. The setting index and
// a torque-scale value looked up from it are driven to the assist datapath.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   pb_n        raw button, asynchronous, active-low (0 = pressed)
//   en          1 = button accepted; 0 = presses ignored, setting held
//   setting     current assist setting index
//   scale       torque scale for the current setting (combinational)
//   short_press one-cycle pulse when a short press is released
//   long_press  one-cycle pulse when the long-hold threshold is reached
module pb_mode_ctrl #(
    parameter int  NUM_LVL  = 4,
    parameter int  RST_LVL  = 2,
    parameter int  SCALE_W  = 3,
    parameter int  DBNC_CYC = 4,
    parameter int  LONG_CYC = 20,
    parameter int  WRAP     = 1,
    localparam int LVL_W    = (NUM_LVL > 2) ? $clog2(NUM_LVL) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pb_n,
    input  logic               en,
    output logic [LVL_W-1:0]   setting,
    output logic [SCALE_W-1:0] scale,
    output logic               short_press,
    output logic               long_press
);

    localparam int DB_W   = $clog2(DBNC_CYC + 1);
    localparam int HOLD_W = $clog2(LONG_CYC + 1);
    // Product width for the scale table; one spare bit so the rounding
    // addend (den-1) can never overflow the intermediate.
    localparam int PW     = LVL_W + SCALE_W + 1;
    localparam int LUT_N  = 2 ** LVL_W;
    localparam logic [LVL_W-1:0] TOP_LVL = LVL_W'(NUM_LVL - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        sync_q,    sync_d;
    logic              pb_db_q,   pb_db_d;
    logic [DB_W-1:0]   db_cnt_q,  db_cnt_d;
    state_t            state_q,   state_d;
    logic [HOLD_W-1:0] hold_q,    hold_d;
    logic [LVL_W-1:0]  setting_q, setting_d;
    logic              short_q,   short_d;
    logic              long_q,    long_d;

    logic              pb_s;
    logic [LVL_W-1:0]  next_lvl;

    // ------------------------------------------------------------------
    // Synchroniser: two flops, reset to the released level
    // ------------------------------------------------------------------
    assign sync_d = {sync_q[0], pb_n};
    assign pb_s   = sync_q[1];

    // ------------------------------------------------------------------
    // Debounce: pb_db only follows pb_s after DBNC_CYC consecutive
    // differing cycles; any agreeing cycle restarts the count.
    // ------------------------------------------------------------------
    always_comb begin
        db_cnt_d = '0;
        pb_db_d  = pb_db_q;
        if (pb_s != pb_db_q) begin
            if (db_cnt_q == DB_W'(DBNC_CYC - 1)) begin
                pb_db_d = pb_s;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Setting advance with wrap / saturate at the top level
    // ------------------------------------------------------------------
    always_comb begin
        next_lvl = setting_q + 1'b1;
        if (setting_q == TOP_LVL) begin
            next_lvl = (WRAP != 0) ? '0 : setting_q;
        end
    end

    // ------------------------------------------------------------------
    // Press classifier FSM. Dropping en always returns to IDLE, so a
    // button still held when en comes back is seen as a fresh press.
    // Release is tested before the long threshold so a coincident
    // release counts as a short press.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        setting_d = setting_q;
        short_d   = 1'b0;
        long_d    = 1'b0;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!pb_db_q) begin
                        state_d = PRESSED;
                        hold_d  = '0;
                    end
                end
                PRESSED: begin
                    hold_d = hold_q + 1'b1;
                    if (pb_db_q) begin
                        state_d   = IDLE;
                        short_d   = 1'b1;
                        setting_d = next_lvl;
                    end else if (hold_q == HOLD_W'(LONG_CYC - 1)) begin
                        state_d   = LONG_HELD;
                        long_d    = 1'b1;
                        setting_d = '0;
                    end
                end
                LONG_HELD: begin
                    if (pb_db_q) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            pb_db_q   <= 1'b1;
            db_cnt_q  <= '0;
            state_q   <= IDLE;
            hold_q    <= '0;
            setting_q <= LVL_W'(RST_LVL);
            short_q   <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            pb_db_q   <= pb_db_d;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            hold_q    <= hold_d;
            setting_q <= setting_d;
            short_q   <= short_d;
            long_q    <= long_d;
        end
    end

    // ------------------------------------------------------------------
    // Scale table: ceil(lvl * (2^SCALE_W - 1) / (NUM_LVL - 1)), folded
    // to constants at elaboration. Unused index codes read as 0.
    // ------------------------------------------------------------------
    function automatic logic [SCALE_W-1:0] calc_scale(input int lvl);
        logic [PW-1:0] num;
        logic [PW-1:0] den;
        logic [PW-1:0] quo;
        num = PW'(lvl) * ((PW'(1) << SCALE_W) - PW'(1));
        den = PW'(NUM_LVL - 1);
        quo = (num + den - PW'(1)) / den;
        return quo[SCALE_W-1:0];
    endfunction

    logic [SCALE_W-1:0] scale_lut [LUT_N];

    for (genvar i = 0; i < LUT_N; i++) begin : g_lut
        if (i < NUM_LVL) begin : g_used
            localparam logic [SCALE_W-1:0] S_VAL = calc_scale(i);
            assign scale_lut[i] = S_VAL;
        end else begin : g_unused
            assign scale_lut[i] = '0;
        end
    end

    assign setting     = setting_q;
    assign scale       = scale_lut[setting_q];
    assign short_press = short_q;
    assign long_press  = long_q;

endmodule

// File: tb/tb_pb_mode_ctrl.sv
// Scoreboard bench for pb_mode_ctrl. Three instances: defaults, WRAP=0
// starting at the top level, and NUM_LVL=6/SCALE_W=4. Stimulus tasks push
// the expected pulse (kind, setting, scale, cycle) into a per-instance
// queue; a negedge monitor pops and compares whenever a pulse appears.
module tb_pb_mode_ctrl;

    localparam int DBNC = 4;
    localparam int LONG = 20;
    localparam int REL_LAT  = 2 + DBNC + 1;        // raw release -> short pulse
    localparam int LONG_LAT = 2 + DBNC + 1 + LONG; // raw press -> long pulse

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_n;
    logic [2:0] pb_n;
    logic [2:0] en;
    logic [1:0] set0, set1;
    logic [2:0] set2;
    logic [2:0] scl0, scl1;
    logic [3:0] scl2;
    logic [2:0] sp, lp;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    pb_mode_ctrl #(.NUM_LVL(4), .RST_LVL(2), .SCALE_W(3), .DBNC_CYC(DBNC),
                   .LONG_CYC(LONG), .WRAP(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .pb_n(pb_n[0]), .en(en[0]),
        .setting(set0), .scale(scl0), .short_press(sp[0]), .long_press(lp[0]));

    pb_mode_ctrl #(.NUM_LVL(4), .RST_LVL(3), .SCALE_W(3), .DBNC_CYC(DBNC),
                   .LONG_CYC(LONG), .WRAP(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .pb_n(pb_n[1]), .en(en[1]),
        .setting(set1), .scale(scl1), .short_press(sp[1]), .long_press(lp[1]));

    pb_mode_ctrl #(.NUM_LVL(6), .RST_LVL(2), .SCALE_W(4), .DBNC_CYC(DBNC),
                   .LONG_CYC(LONG), .WRAP(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n[2]), .pb_n(pb_n[2]), .en(en[2]),
        .setting(set2), .scale(scl2), .short_press(sp[2]), .long_press(lp[2]));

    typedef struct {
        int kind;  // 0 short, 1 long
        int st;
        int sc;
        int cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    function automatic int cur_set(input int d);
        case (d)
            0:       return int'(set0);
            1:       return int'(set1);
            default: return int'(set2);
        endcase
    endfunction

    function automatic int cur_scl(input int d);
        case (d)
            0:       return int'(scl0);
            1:       return int'(scl1);
            default: return int'(scl2);
        endcase
    endfunction

    function automatic int q_size(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push(input int d, input int kind, input int st, input int sc, input int c);
        exp_t e;
        e.kind = kind; e.st = st; e.sc = sc; e.cyc = c;
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic mon(input int d);
        exp_t e;
        int   k_act;
        int   st;
        int   sc;
        if (sp[d] || lp[d]) begin
            checks++;
            st    = cur_set(d);
            sc    = cur_scl(d);
            k_act = (sp[d] && lp[d]) ? 2 : (lp[d] ? 1 : 0);
            if (q_size(d) == 0) begin
                errors++;
                $display("FAIL unexpected_pulse dut%0d: got kind=%0d setting=%0d scale=%0d at cyc %0d, need no pulse",
                         d, k_act, st, sc, cyc);
            end else begin
                case (d)
                    0:       e = q0.pop_front();
                    1:       e = q1.pop_front();
                    default: e = q2.pop_front();
                endcase
                if (k_act != e.kind || st != e.st || sc != e.sc || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL pulse dut%0d: got kind=%0d setting=%0d scale=%0d cyc=%0d, need kind=%0d setting=%0d scale=%0d cyc=%0d",
                             d, k_act, st, sc, cyc, e.kind, e.st, e.sc, e.cyc);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) mon(d);
    end

    task automatic check_val(input int d, input string name, input int est, input int esc);
        checks++;
        if (cur_set(d) != est || cur_scl(d) != esc) begin
            errors++;
            $display("FAIL %s dut%0d: got setting=%0d scale=%0d, need setting=%0d scale=%0d",
                     name, d, cur_set(d), cur_scl(d), est, esc);
        end
    endtask

    // kind: 0 short, 1 long, -1 no pulse expected
    task automatic press(input int d, input int low, input int high,
                         input int kind, input int st, input int sc);
        @(posedge clk); #1;
        pb_n[d] = 1'b0;
        if (kind == 1) push(d, 1, st, sc, cyc + LONG_LAT);
        repeat (low) @(posedge clk);
        #1;
        pb_n[d] = 1'b1;
        if (kind == 0) push(d, 0, st, sc, cyc + REL_LAT);
        repeat (high) @(posedge clk);
    endtask

    int exp_s2 [6] = '{3, 4, 5, 0, 1, 2};
    int exp_c2 [6] = '{9, 12, 15, 0, 3, 6};

    initial begin
        rst_n = 3'b000;
        pb_n  = 3'b111;
        en    = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        check_val(0, "in_reset", 2, 5);
        check_val(1, "in_reset", 3, 7);
        check_val(2, "in_reset", 2, 6);
        checks++;
        if ((sp | lp) != 3'b000) begin
            errors++;
            $display("FAIL reset_pulses: got sp=%b lp=%b, need 000 000", sp, lp);
        end
        rst_n = 3'b111;

        // idle hold
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            check_val(0, "idle_hold", 2, 5);
        end

        // bounces shorter than the debounce window
        for (int i = 0; i < 5; i++) press(0, 3, 10, -1, 0, 0);
        check_val(0, "bounce", 2, 5);

        // short presses with wrap
        press(0, 8, 15, 0, 3, 7);
        check_val(0, "short1", 3, 7);
        press(0, 8, 15, 0, 0, 0);
        check_val(0, "short2_wrap", 0, 0);
        press(0, 8, 15, 0, 1, 3);
        check_val(0, "short3", 1, 3);

        // long press, release gives nothing further
        press(0, 40, 20, 1, 0, 0);
        check_val(0, "after_long", 0, 0);

        // WRAP=0: saturate at top, en gating
        press(1, 8, 15, 0, 3, 7);
        check_val(1, "saturate", 3, 7);
        en[1] = 1'b0;
        press(1, 8, 15, -1, 0, 0);
        check_val(1, "en_low", 3, 7);
        en[1] = 1'b1;
        repeat (5) @(posedge clk);
        press(1, 40, 20, 1, 0, 0);
        check_val(1, "long_nowrap", 0, 0);
        press(1, 8, 15, 0, 1, 3);
        check_val(1, "short_from0", 1, 3);

        // NUM_LVL=6, SCALE_W=4: walk all settings
        for (int i = 0; i < 6; i++) begin
            press(2, 8, 15, 0, exp_s2[i], exp_c2[i]);
            check_val(2, "walk6", exp_s2[i], exp_c2[i]);
        end
        press(2, 8, 15, 0, 3, 9);
        check_val(2, "pre_rst", 3, 9);

        // reset in the middle of a held press
        @(posedge clk); #1;
        pb_n[2] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst_n[2] = 1'b0;
        #1;
        check_val(2, "mid_rst", 2, 6);
        repeat (2) @(posedge clk);
        #1;
        rst_n[2] = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check_val(2, "rst_held", 2, 6);
        pb_n[2] = 1'b1;
        push(2, 0, 3, 9, cyc + REL_LAT);
        repeat (15) @(posedge clk);
        #1;
        check_val(2, "post_rst_press", 3, 9);

        repeat (30) @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (q_size(d) != 0) begin
                errors++;
                $display("FAIL missing_pulse dut%0d: got %0d pulses outstanding, need 0", d, q_size(d));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pb_mode_ctrl.md
Name: pb_mode_ctrl

Overview:
Parametrised push-button mode controller for the e-bike assist-level selector. It synchronises and debounces one raw active-low button and classifies each press as short or long. A short press advances the assist setting; a long press forces assist off. It drives the setting index and a derived torque-scale value to the assist datapath.

Parameters:
NUM_LVL, 4, number of assist settings (>=2); LVL_W = max(1, $clog2(NUM_LVL)) localparam
RST_LVL, 2, setting loaded at reset (< NUM_LVL)
SCALE_W, 3, width of scale output
DBNC_CYC, 4, consecutive stable cycles required to accept a new button level (>=1)
LONG_CYC, 20, cycles held in PRESSED before press is classified long (>=1)
WRAP, 1, 1: short press at top setting wraps to 0; 0: saturates at NUM_LVL-1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pb_n  in  1  raw button, asynchronous, active-low (0 = pressed)
en  in  1  1 = button accepted; 0 = presses ignored, setting held
setting  out  LVL_W  current assist setting index
scale  out  SCALE_W  torque scale for current setting
short_press  out  1  one-cycle pulse on short-press release
long_press  out  1  one-cycle pulse when long threshold is reached

Behaviour:
- Reset values: sync flops=1, debounced level pb_db=1, FSM=IDLE, counters=0, setting=RST_LVL, short_press=0, long_press=0.
- Synchroniser: two flops on pb_n, output pb_s.
- Debounce:
  - Counter increments while pb_s != pb_db and clears whenever pb_s == pb_db.
  - pb_db takes pb_s on the edge ending the DBNC_CYC-th consecutive differing cycle. The counter clears on that edge.
  - Glitches shorter than DBNC_CYC cycles never change pb_db.
- FSM states: IDLE, PRESSED, LONG_HELD.
  - IDLE -> PRESSED on pb_db==0 && en. Hold counter cleared.
  - PRESSED:
    - Hold counter increments each cycle.
    - If pb_db==1 → IDLE, short_press=1 for one cycle, setting advances.
    - Else if hold count == LONG_CYC-1 → LONG_HELD, long_press=1 for one cycle, setting <= 0.
    - If release and threshold occur in the same cycle, release wins (short press).
  - LONG_HELD → IDLE on pb_db==1. No pulse, no setting change.
  - en==0 in any state → IDLE next edge, no pulses, setting held. A button still held when en returns high is treated as a new press.
- Setting advance:
  - setting+1 if setting < NUM_LVL-1.
  - At NUM_LVL-1: 0 if WRAP=1, unchanged if WRAP=0. short_press still pulses in the saturated case.
- Timing:
  - setting and pulses are registered and update on the same edge, one cycle after the pb_db edge that triggers them.
  - Total latency from a raw pb_n edge is 2 + DBNC_CYC + 1 cycles.
- scale is combinational from setting:
  - scale = ceil(setting * (2^SCALE_W - 1) / (NUM_LVL-1)), evaluated at elaboration into a constant table.
  - Defaults give 0,3,5,7.
  - Width rules: the intermediate product is at least LVL_W+SCALE_W bits; the result always fits SCALE_W.
- Reset mid-press: all state returns to its reset values immediately. A still-held button re-debounces (pb_db was reset to 1) and counts as a new press. No pulse fires for the interrupted press.
- Pulses never overlap, and at most one pulse fires per physical press.

Test Plan:
- Reset with defaults → setting=2, scale=5, short_press=long_press=0; all hold for 50 idle cycles with pb_n=1.
- Three short presses (pb_n low 8 cycles, high 15) → setting 3,0,1 and scale 7,0,3. Exactly one short_press per press, asserted 7 cycles after the raw release edge.
- Bounce: pb_n low 3 cycles, then high; repeat 5 times → no FSM change, no pulses, setting=2.
- Hold pb_n low 40 cycles → long_press single pulse 20 cycles after PRESSED entry; setting=0, scale=0. The following release gives no short_press and setting stays 0.
- WRAP=0 instance from setting 3: short press → setting stays 3, short_press pulses. en=0 during a full short press → no pulse, setting unchanged.
- NUM_LVL=6, SCALE_W=4: step through all settings → scale 0,3,6,9,12,15, wrapping to 0. Assert rst_n low mid-press with pb_n held → setting=RST_LVL, no pulse. The held button is then re-accepted as a new press, and its release advances the setting.
